butterfly_s2p_pack: RTL and testbench

Serial-to-parallel packer on the butterfly datapath. It collects a stream of `data_width`-bit words into `num_output`-lane vectors and feeds the parallel-input engines, so it is the receive-side counterpart of the parallel-to-serial stage. A bypass mode forwards already-parallel beats through the same registered output. An optional row-length flush zero-pads and emits the last, partial vector of each row.

---
 rtl/butterfly_s2p_pack.sv | 142 ++++++++++++++
 tb/tb_butterfly_s2p_pack.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/butterfly_s2p_pack.sv
// Serial-to-parallel packer: gathers data_width-bit words into num_output-lane vectors,
// with a parallel bypass path. Define BUTTERFLY_S2P_FLUSH_EN for row-length zero-pad flush.
module butterfly_s2p_pack #(
  parameter int data_width = 16,
  parameter int num_output = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             by_pass,
  input  logic [15:0]                      length,
  input  logic [data_width-1:0]            up_serial_dat,
  input  logic                             up_serial_vld,
  output logic                             up_serial_rdy,
  input  logic [num_output*data_width-1:0] up_parallel_dat,
  input  logic                             up_parallel_vld,
  output logic                             up_parallel_rdy,
  output logic [num_output*data_width-1:0] dn_dat,
  output logic                             dn_vld,
  input  logic                             dn_rdy,
  output logic                             dn_last
);

  localparam int PW = $clog2(num_output);
  localparam logic [PW-1:0] LAST_LANE = PW'(num_output - 1);

  typedef logic [num_output-1:0][data_width-1:0] vec_t;

  vec_t          asm_q, asm_d;
  vec_t          dn_dat_q, dn_dat_d;
  vec_t          merged;
  logic [PW-1:0] ptr_q, ptr_d;
  logic          dn_vld_q, dn_vld_d;

  logic out_free;
  logic row_end;
  logic complete;
  logic accept_s;
  logic accept_p;

  assign out_free = ~dn_vld_q | dn_rdy;
  assign complete = (ptr_q == LAST_LANE) | row_end;

  // Ready depends only on state, by_pass and dn_rdy, never on the vld inputs.
  assign up_serial_rdy   = ~by_pass & (~complete | out_free);
  assign up_parallel_rdy = by_pass & out_free & (ptr_q == '0);

  assign accept_s = up_serial_vld & up_serial_rdy;
  assign accept_p = up_parallel_vld & up_parallel_rdy;

  // Lanes below ptr keep their words, lane ptr takes the new word, lanes above read as zero.
  always_comb begin
    merged = '0;
    for (int i = 0; i < num_output; i++) begin
      if (PW'(i) < ptr_q) begin
        merged[i] = asm_q[i];
      end else if (PW'(i) == ptr_q) begin
        merged[i] = up_serial_dat;
      end
    end
  end

  // NOTE: every variable assigned in a combinational block gets a default first, so no latch is inferred.
  always_comb begin
    asm_d    = asm_q;
    ptr_d    = ptr_q;
    dn_dat_d = dn_dat_q;
    dn_vld_d = dn_vld_q & ~dn_rdy;
    if (accept_s) begin
      if (complete) begin
        dn_dat_d = merged;
        dn_vld_d = 1'b1;
        asm_d    = '0;
        ptr_d    = '0;
      end else begin
        asm_d = merged;
        ptr_d = ptr_q + PW'(1);
      end
    end else if (accept_p) begin
      dn_dat_d = up_parallel_dat;
      dn_vld_d = 1'b1;
    end
  end

  // NOTE: state uses non-blocking assignments; the assembly buffer is a real register and is reset
  // so a vector interrupted by rst can never leak stale lanes into the next one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      asm_q    <= '0;
      ptr_q    <= '0;
      dn_dat_q <= '0;
      dn_vld_q <= 1'b0;
    end else begin
      asm_q    <= asm_d;
      ptr_q    <= ptr_d;
      dn_dat_q <= dn_dat_d;
      dn_vld_q <= dn_vld_d;
    end
  end

  assign dn_dat = dn_dat_q;
  assign dn_vld = dn_vld_q;

`ifdef BUTTERFLY_S2P_FLUSH_EN
  logic [15:0] cnt_q, cnt_d;
  logic        dn_last_q, dn_last_d;

  // length == 0 disables flushing and keeps the row counter parked at zero.
  assign row_end = (length != 16'd0) && (cnt_q == length - 16'd1);

  always_comb begin
    cnt_d     = cnt_q;
    dn_last_d = dn_last_q & ~dn_rdy;
    if (accept_s) begin
      cnt_d = (row_end || length == 16'd0) ? 16'd0 : cnt_q + 16'd1;
      if (complete) begin
        dn_last_d = row_end;
      end
    end else if (accept_p) begin
      dn_last_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= 16'd0;
      dn_last_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      dn_last_q <= dn_last_d;
    end
  end

  assign dn_last = dn_last_q;
`else
  logic unused_length;

  assign row_end       = 1'b0;
  assign dn_last       = 1'b0;
  assign unused_length = ^length;
`endif

endmodule

// File: tb/tb_butterfly_s2p_pack.sv
// Directed self-checking bench for butterfly_s2p_pack: fill, backpressure, row flush or
// contiguous packing, bypass, asynchronous reset mid-vector and by_pass toggle mid-vector.
module tb_butterfly_s2p_pack;

  localparam int DW = 16;
  localparam int NO = 8;
  localparam int VW = DW * NO;

  logic          clk = 1'b0;
  logic          rst;
  logic          by_pass;
  logic [15:0]   length;
  logic [DW-1:0] up_serial_dat;
  logic          up_serial_vld;
  logic          up_serial_rdy;
  logic [VW-1:0] up_parallel_dat;
  logic          up_parallel_vld;
  logic          up_parallel_rdy;
  logic [VW-1:0] dn_dat;
  logic          dn_vld;
  logic          dn_rdy;
  logic          dn_last;

  int checks = 0;
  int errors = 0;

  butterfly_s2p_pack #(.data_width(DW), .num_output(NO)) dut (
    .clk             (clk),
    .rst             (rst),
    .by_pass         (by_pass),
    .length          (length),
    .up_serial_dat   (up_serial_dat),
    .up_serial_vld   (up_serial_vld),
    .up_serial_rdy   (up_serial_rdy),
    .up_parallel_dat (up_parallel_dat),
    .up_parallel_vld (up_parallel_vld),
    .up_parallel_rdy (up_parallel_rdy),
    .dn_dat          (dn_dat),
    .dn_vld          (dn_vld),
    .dn_rdy          (dn_rdy),
    .dn_last         (dn_last)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Lanes 0..n-1 hold first, first+1, ...; remaining lanes are zero.
  function automatic logic [VW-1:0] vec_seq(input int first, input int n);
    logic [VW-1:0] v;
    v = '0;
    for (int i = 0; i < NO; i++) begin
      if (i < n) v[i*DW +: DW] = DW'(first + i);
    end
    return v;
  endfunction

  function automatic logic [VW-1:0] beat(input int k);
    logic [VW-1:0] v;
    for (int i = 0; i < NO; i++) v[i*DW +: DW] = DW'(32'hB000 + (k << 4) + i);
    return v;
  endfunction

  initial begin
    rst = 1'b1;
    by_pass = 1'b0;
    length = 16'd0;
    up_serial_dat = '0;
    up_serial_vld = 1'b0;
    up_parallel_dat = '0;
    up_parallel_vld = 1'b0;
    dn_rdy = 1'b1;
    #2;
    check("rst_dn_vld", dn_vld, 1'b0);
    check("rst_dn_dat", dn_dat, '0);
    check("rst_dn_last", dn_last, 1'b0);
    check("rst_serial_rdy", up_serial_rdy, 1'b1);
    check("rst_parallel_rdy", up_parallel_rdy, 1'b0);
    by_pass = 1'b1;
    #1;
    check("rst_bp_serial_rdy", up_serial_rdy, 1'b0);
    check("rst_bp_parallel_rdy", up_parallel_rdy, 1'b1);
    by_pass = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();

    // Fill: eight back-to-back words form vector 1.
    for (int w = 1; w <= 8; w++) begin
      up_serial_dat = DW'(w);
      up_serial_vld = 1'b1;
      #1;
      check("fill_rdy", up_serial_rdy, 1'b1);
      step();
      if (w == 7) check("fill_vld_early", dn_vld, 1'b0);
    end
    check("fill_vld", dn_vld, 1'b1);
    check("fill_dat", dn_dat, vec_seq(1, 8));
    check("fill_last", dn_last, 1'b0);

    // Backpressure: vector 1 held while words 9..15 fill, word 16 stalls.
    dn_rdy = 1'b0;
    for (int w = 9; w <= 15; w++) begin
      up_serial_dat = DW'(w);
      #1;
      check("bp_rdy", up_serial_rdy, 1'b1);
      step();
    end
    check("bp_hold_vld", dn_vld, 1'b1);
    check("bp_hold_dat", dn_dat, vec_seq(1, 8));
    up_serial_dat = DW'(16);
    #1;
    check("bp_stall_rdy", up_serial_rdy, 1'b0);
    step();
    check("bp_stall_rdy2", up_serial_rdy, 1'b0);
    check("bp_stall_dat", dn_dat, vec_seq(1, 8));
    dn_rdy = 1'b1;
    #1;
    check("bp_release_rdy", up_serial_rdy, 1'b1);
    step();
    check("bp_v2_vld", dn_vld, 1'b1);
    check("bp_v2_dat", dn_dat, vec_seq(9, 8));
    up_serial_vld = 1'b0;
    step();
    check("bp_drain_vld", dn_vld, 1'b0);

    length = 16'd11;
`ifdef BUTTERFLY_S2P_FLUSH_EN
    for (int w = 1; w <= 11; w++) begin
      up_serial_dat = DW'(w);
      up_serial_vld = 1'b1;
      step();
      if (w == 8) begin
        check("flush_v1_dat", dn_dat, vec_seq(1, 8));
        check("flush_v1_last", dn_last, 1'b0);
      end
    end
    check("flush_v2_vld", dn_vld, 1'b1);
    check("flush_v2_dat", dn_dat, vec_seq(9, 3));
    check("flush_v2_last", dn_last, 1'b1);
`else
    for (int w = 1; w <= 16; w++) begin
      up_serial_dat = DW'(w);
      up_serial_vld = 1'b1;
      step();
      if (w == 8) begin
        check("noflush_v1_dat", dn_dat, vec_seq(1, 8));
        check("noflush_v1_last", dn_last, 1'b0);
      end
      if (w == 11) check("noflush_no_early", dn_vld, 1'b0);
    end
    check("noflush_v2_vld", dn_vld, 1'b1);
    check("noflush_v2_dat", dn_dat, vec_seq(9, 8));
    check("noflush_v2_last", dn_last, 1'b0);
`endif
    up_serial_vld = 1'b0;
    length = 16'd0;
    step();
    check("row_drain_vld", dn_vld, 1'b0);

    // Bypass: four back-to-back beats, each visible one cycle later.
    by_pass = 1'b1;
    #1;
    check("byp_serial_rdy", up_serial_rdy, 1'b0);
    for (int k = 0; k < 4; k++) begin
      up_parallel_dat = beat(k);
      up_parallel_vld = 1'b1;
      #1;
      check("byp_par_rdy", up_parallel_rdy, 1'b1);
      step();
      check("byp_vld", dn_vld, 1'b1);
      check("byp_dat", dn_dat, beat(k));
    end
    up_parallel_vld = 1'b0;
    step();
    check("byp_drain_vld", dn_vld, 1'b0);

    dn_rdy = 1'b0;
    up_parallel_dat = beat(5);
    up_parallel_vld = 1'b1;
    step();
    check("byp_bp_dat", dn_dat, beat(5));
    up_parallel_dat = beat(6);
    #1;
    check("byp_bp_rdy_low", up_parallel_rdy, 1'b0);
    step();
    check("byp_bp_hold", dn_dat, beat(5));
    dn_rdy = 1'b1;
    #1;
    check("byp_bp_rdy_high", up_parallel_rdy, 1'b1);
    step();
    check("byp_bp_next", dn_dat, beat(6));
    up_parallel_vld = 1'b0;
    dn_rdy = 1'b0;
    by_pass = 1'b0;

    // Reset mid-vector with an output still pending.
    for (int w = 1; w <= 5; w++) begin
      up_serial_dat = DW'(32'h0100 + w);
      up_serial_vld = 1'b1;
      step();
    end
    up_serial_vld = 1'b0;
    check("mid_pending_vld", dn_vld, 1'b1);
    rst = 1'b1;
    #1;
    check("mid_rst_vld", dn_vld, 1'b0);
    check("mid_rst_dat", dn_dat, '0);
    step();
    rst = 1'b0;
    dn_rdy = 1'b1;
    for (int w = 1; w <= 8; w++) begin
      up_serial_dat = DW'(32'h0200 + w);
      up_serial_vld = 1'b1;
      step();
    end
    check("mid_new_vld", dn_vld, 1'b1);
    check("mid_new_dat", dn_dat, vec_seq(32'h0201, 8));
    up_serial_vld = 1'b0;
    step();

    // by_pass toggled with a partial vector: parallel path stalls, partial lanes survive.
    for (int w = 1; w <= 3; w++) begin
      up_serial_dat = DW'(32'h0300 + w);
      up_serial_vld = 1'b1;
      step();
    end
    up_serial_vld = 1'b0;
    by_pass = 1'b1;
    up_parallel_dat = beat(7);
    up_parallel_vld = 1'b1;
    #1;
    check("tog_par_rdy", up_parallel_rdy, 1'b0);
    step();
    check("tog_no_load", dn_vld, 1'b0);
    up_parallel_vld = 1'b0;
    by_pass = 1'b0;
    for (int w = 4; w <= 8; w++) begin
      up_serial_dat = DW'(32'h0300 + w);
      up_serial_vld = 1'b1;
      step();
    end
    up_serial_vld = 1'b0;
    check("tog_vec_dat", dn_dat, vec_seq(32'h0301, 8));
    step();
    check("tog_drain_vld", dn_vld, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
